// File: rtl/llvm_share_pkg.sv
// Shared definitions for the LLVM op-unit sharing wrappers.
//  - share_state_e : sharer FSM states
//  - rr_pick()     : round-robin winner search, usable by any sharer
//                    with up to MAX_REQ requesters
package llvm_share_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} share_state_e;

   localparam int unsigned MAX_REQ   = 16;
   localparam int unsigned MAX_REQ_W = 4;

   // Returns the first index i with req[i] set, scanning from (last+1)
   // mod n and wrapping; -1 when no requester is active.
   // Expects last < n <= MAX_REQ.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                  input int unsigned       last,
                                  input int unsigned       n);
      int          pick;
      int unsigned idx;
      pick = -1;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         idx = last + k;
         if (idx >= n) idx = idx - n;
         if ((k <= n) && (pick < 0) && req[idx[MAX_REQ_W-1:0]]) pick = int'(idx);
      end
      return pick;
   endfunction

endpackage

// File: rtl/llvm_rr_arbiter.sv
// Combinational round-robin arbiter.
//  req_vec    in  NUM_REQ          active requesters
//  last_grant in  $clog2(NUM_REQ)  most recently granted index
//  gnt_onehot out NUM_REQ          one-hot winner, zero when none
//  gnt_id     out $clog2(NUM_REQ)  winner index, 0 when none
//  gnt_any    out 1                some requester won
module llvm_rr_arbiter
   import llvm_share_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_vec,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         gnt_onehot,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       gnt_any
);

   localparam int ID_W = $clog2(NUM_REQ);

   int pick;

   always_comb begin
      pick       = rr_pick(MAX_REQ'(req_vec), 32'(last_grant), unsigned'(NUM_REQ));
      gnt_any    = (pick >= 0);
      gnt_onehot = '0;
      gnt_id     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == i) begin
            gnt_onehot[i] = 1'b1;
            gnt_id        = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/llvm_unary_share_rr.sv
// Time-shares one valid/ready unary op unit between NUM_REQ requesters.
// Round-robin grant, one operation in flight, result returned only to the
// requester that issued it.
//
// Handshake semantics (all channels): a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. A producer holds
// valid and data stable until the transfer; ready may depend
// combinationally on valid.
//
// Ports:
//  clk, rst_n          clock, async active-low reset
//  req_valid/ready/data  operand channels, requester i at [i*WIDTH +: WIDTH]
//  rsp_valid/ready       per-requester result channels; rsp_data broadcast
//  op_a_*              operand channel to the shared unit
//  op_result_*         result channel from the shared unit
//  busy                FSM not idle
//  cur_id              owner of the current transaction, 0 when idle
module llvm_unary_share_rr
   import llvm_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       op_a_valid,
   input  logic                       op_a_ready,
   output logic [WIDTH-1:0]           op_a_data,
   input  logic                       op_result_valid,
   output logic                       op_result_ready,
   input  logic [WIDTH-1:0]           op_result_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] cur_id
);

   localparam int ID_W = $clog2(NUM_REQ);

   share_state_e    state, state_d;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] id_q;
   logic [WIDTH-1:0] arg_q;
   logic [WIDTH-1:0] res_q;

   logic [NUM_REQ-1:0] gnt_onehot;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;

   llvm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_vec    (req_valid),
      .last_grant (last_grant),
      .gnt_onehot (gnt_onehot),
      .gnt_id     (gnt_id),
      .gnt_any    (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         id_q       <= '0;
         arg_q      <= '0;
         res_q      <= '0;
      end else begin
         state <= state_d;
         // In IDLE the winner's ready is driven high, so a grant is a transfer.
         if ((state == S_IDLE) && gnt_any) begin
            arg_q      <= req_data[int'(gnt_id)*WIDTH +: WIDTH];
            id_q       <= gnt_id;
            last_grant <= gnt_id;
         end
         // op_result_ready is only high in ISSUE (with accept) and WAIT.
         if (op_result_valid && op_result_ready) res_q <= op_result_data;
      end
   end

   always_comb begin
      state_d         = state;
      req_ready       = '0;
      rsp_valid       = '0;
      op_a_valid      = 1'b0;
      op_result_ready = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = gnt_onehot;
            if (gnt_any) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            op_a_valid = 1'b1;
            // A combinational unit answers in the accept cycle; take the
            // result only together with the accept.
            op_result_ready = op_a_ready;
            if (op_a_ready) state_d = op_result_valid ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            op_result_ready = 1'b1;
            if (op_result_valid) state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid[id_q] = 1'b1;
            if (rsp_ready[id_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign op_a_data = arg_q;
   assign rsp_data  = res_q;
   assign busy      = (state != S_IDLE);
   assign cur_id    = (state == S_IDLE) ? '0 : id_q;

endmodule

// File: tb/tb_llvm_unary_share_rr.sv
module tb_llvm_unary_share_rr;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]         rsp_data;
   logic                     op_a_valid;
   logic                     op_a_ready;
   logic [WIDTH-1:0]         op_a_data;
   logic                     op_result_valid;
   logic                     op_result_ready;
   logic [WIDTH-1:0]         op_result_data;
   logic                     busy;
   logic [1:0]               cur_id;

   llvm_unary_share_rr #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .op_a_valid      (op_a_valid),
      .op_a_ready      (op_a_ready),
      .op_a_data       (op_a_data),
      .op_result_valid (op_result_valid),
      .op_result_ready (op_result_ready),
      .op_result_data  (op_result_data),
      .busy            (busy),
      .cur_id          (cur_id)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   // ---------------- shared unit: bitreverse, comb or multi-cycle ----------------
   logic       mc_mode = 1'b0;
   logic       stray   = 1'b0;
   int         a_cnt, r_cnt;
   logic       pend;
   logic [7:0] res_hold;

   always_comb begin
      if (!mc_mode) begin
         op_a_ready      = 1'b1;
         op_result_valid = op_a_valid | stray;
         op_result_data  = stray ? 8'hAA : bitrev(op_a_data);
      end else begin
         op_a_ready      = (a_cnt >= 2) && !pend;
         op_result_valid = (pend && (r_cnt >= 3)) | stray;
         op_result_data  = pend ? res_hold : 8'hAA;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !mc_mode) begin
         a_cnt <= 0; r_cnt <= 0; pend <= 1'b0; res_hold <= '0;
      end else begin
         if (op_a_valid && op_a_ready) begin
            pend <= 1'b1; r_cnt <= 0; a_cnt <= 0; res_hold <= bitrev(op_a_data);
         end else if (op_a_valid) begin
            a_cnt <= a_cnt + 1;
         end
         if (pend) begin
            if (op_result_valid && op_result_ready) pend <= 1'b0;
            else if (r_cnt < 3) r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [WIDTH-1:0]   exp_q[$];
   int                 exp_id_q[$];
   int                 exp_t_q[$];
   int                 grant_id_log[$];
   int                 grant_cyc_log[$];
   int                 model_last = NUM_REQ - 1;
   logic [NUM_REQ-1:0] last_req_hs = '0;
   logic               lat_chk = 1'b0;

   function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++)
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [NUM_REQ-1:0] hs;
      int w;
      if (!rst_n) begin
         exp_q.delete(); exp_id_q.delete(); exp_t_q.delete();
         model_last  = NUM_REQ - 1;
         last_req_hs = '0;
      end else begin
         hs          = req_valid & req_ready;
         last_req_hs = hs;
         check_val("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
         check_val("ready_with_rsp", 32'((|req_ready) && (|rsp_valid)), 0);
         if (!busy) check_val("opres_ready_idle", 32'(op_result_ready), 0);
         if (hs != '0) begin
            w = model_pick(req_valid, model_last);
            check_val("grant", 32'(hs), 32'(1) << w);
            model_last = w;
            exp_q.push_back(bitrev(req_data[w*WIDTH +: WIDTH]));
            exp_id_q.push_back(w);
            exp_t_q.push_back(cyc);
            grant_id_log.push_back(w);
            grant_cyc_log.push_back(cyc);
         end
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               check_val("stray_rsp", 32'(rsp_valid), 0);
            end else begin
               check_val("rsp_owner", 32'(rsp_valid), 32'(1) << exp_id_q[0]);
               if ((rsp_valid & rsp_ready) != '0) begin
                  check_val("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
                  if (lat_chk) check_val("latency", cyc - exp_t_q[0], 2);
                  void'(exp_q.pop_front());
                  void'(exp_id_q.pop_front());
                  void'(exp_t_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_req_ready"}, 32'(req_ready), 0);
      check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
      check_val({tag, "_op_a_valid"}, 32'(op_a_valid), 0);
      check_val({tag, "_op_res_ready"}, 32'(op_result_ready), 0);
      check_val({tag, "_busy"}, 32'(busy), 0);
      check_val({tag, "_cur_id"}, 32'(cur_id), 0);
   endtask

   // Raise one request, wait for its transfer, then drop it.
   task automatic send(input int id, input logic [WIDTH-1:0] d);
      logic got;
      got = 1'b0;
      req_valid[id] = 1'b1;
      req_data[id*WIDTH +: WIDTH] = d;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
         next_cycle();
      end
      req_valid[id] = 1'b0;
      if (!got) check_val("send_timeout", 0, 1);
   endtask

   task automatic drain();
      logic done;
      done      = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) done = 1'b1;
      end
      check_val("drain", 32'(done), 1);
      next_cycle();
   endtask

   task automatic run_random(input int ncyc, input int p_req);
      for (int c = 0; c < ncyc; c++) begin
         next_cycle();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || last_req_hs[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < p_req);
               req_data[i*WIDTH +: WIDTH] = 8'($urandom);
            end
            rsp_ready[i] = ($urandom_range(0, 99) < 70);
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int held;
      logic acc;
      logic found;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = '1;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      check_outputs_zero("reset");
      check_val("reset_op_a_data", 32'(op_a_data), 0);
      check_val("reset_rsp_data", 32'(rsp_data), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1. single request, combinational unit
      lat_chk = 1'b1;
      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h01;
      @(negedge clk);
      check_val("t1_ready", 32'(req_ready), 32'h1);
      next_cycle();
      req_valid[0] = 1'b0;
      @(negedge clk);
      check_val("t1_rsp_t1", 32'(rsp_valid), 0);
      @(negedge clk);
      check_val("t1_rsp_t2", 32'(rsp_valid), 32'h1);
      check_val("t1_data", 32'(rsp_data), 32'h80);
      next_cycle();
      drain();

      // 2. all four requesting, round-robin at one op per 3 cycles
      do_reset();
      grant_id_log.delete();
      grant_cyc_log.delete();
      req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
      req_valid = '1;
      repeat (26) next_cycle();
      req_valid = '0;
      drain();
      check_val("t2_grant_count", 32'(grant_id_log.size() >= 8), 1);
      for (int k = 0; k < 8 && k < grant_id_log.size(); k++) begin
         check_val("t2_order", grant_id_log[k], k % NUM_REQ);
         if (k > 0) check_val("t2_spacing", grant_cyc_log[k] - grant_cyc_log[k-1], 3);
      end
      lat_chk = 1'b0;

      // 3. response backpressure on requester 2
      do_reset();
      rsp_ready = 4'b1011;
      send(2, 8'h0F);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) found = 1'b1;
      end
      check_val("t3_rsp_seen", 32'(found), 1);
      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h5A;
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         @(negedge clk);
         check_val("t3_hold_valid", 32'(rsp_valid), 32'h4);
         check_val("t3_hold_data", 32'(rsp_data), 32'hF0);
         check_val("t3_no_ready", 32'(req_ready), 0);
      end
      next_cycle();
      rsp_ready = '1;
      send(0, 8'h5A);
      drain();

      // 4. multi-cycle unit
      mc_mode = 1'b1;
      do_reset();
      send(1, 8'h35);
      held = 0;
      acc  = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
         @(negedge clk);
         check_val("t4_issue_valid", 32'(op_a_valid), 1);
         check_val("t4_issue_data", 32'(op_a_data), 32'h35);
         if (op_a_ready) acc = 1'b1;
         else held++;
         next_cycle();
      end
      check_val("t4_issue_hold", held, 2);
      @(negedge clk);
      check_val("t4_wait_a_valid", 32'(op_a_valid), 0);
      check_val("t4_wait_busy", 32'(busy), 1);
      check_val("t4_wait_cur_id", 32'(cur_id), 1);
      check_val("t4_wait_res_ready", 32'(op_result_ready), 1);
      drain();

      // 5. reset during WAIT
      do_reset();
      send(2, 8'($urandom));
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (busy && !op_a_valid && rsp_valid == '0) found = 1'b1;
         else next_cycle();
      end
      check_val("t5_wait_seen", 32'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      check_outputs_zero("t5_async");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      req_data  = {8'h11, 8'h22, 8'h33, 8'h44};
      req_valid = '1;
      @(negedge clk);
      check_val("t5_first_grant", 32'(req_ready), 32'h1);
      next_cycle();
      req_valid = '0;
      drain();

      // 6. spurious result while idle
      mc_mode = 1'b0;
      do_reset();
      stray = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("t6_res_ready", 32'(op_result_ready), 0);
         check_val("t6_busy", 32'(busy), 0);
         next_cycle();
      end
      stray = 1'b0;
      next_cycle();

      // random traffic, both unit styles
      run_random(300, 60);
      drain();
      mc_mode = 1'b1;
      run_random(300, 50);
      drain();
      mc_mode = 1'b0;
      run_random(200, 90);
      drain();
      check_val("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
